// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-thread memory port arbiter.
package mem_arbiter_pkg;

  localparam int AW = 16;
  localparam int DW = 16;

  typedef logic [DW-1:0] word_t;
  typedef logic [AW-1:0] addr_t;

  localparam logic T0 = 1'b0;
  localparam logic T1 = 1'b1;

  // IDLE arbitrates between both threads; OWNn serves only thread n (lock held).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Thread request ports, memory port and debug owner of the arbiter.
//
// Handshake: a thread raises reqN with weN/lockN/addrN/wdataN stable and holds
// them until gntN is high in the same cycle; gntN high means the access was
// issued to memory in that cycle. There is no backpressure on the return path:
// rvalidN is a single-cycle pulse one cycle after a load grant.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic  req0,   req1;
  logic  we0,    we1;
  logic  lock0,  lock1;
  addr_t addr0,  addr1;
  word_t wdata0, wdata1;
  logic  halt0,  halt1;
  logic  gnt0,   gnt1;
  logic  rvalid0, rvalid1;
  word_t rdata0, rdata1;
  logic  mem_en;
  logic  mem_we;
  addr_t mem_addr;
  word_t mem_wdata;
  word_t mem_rdata;
  logic [1:0] owner;

  // Threads plus memory side: drives requests and memory read data.
  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1,
           wdata0, wdata1, halt0, halt1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata, owner
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1,
           wdata0, wdata1, halt0, halt1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata, owner
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, the thread not granted last wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       id
);

  // One-hot grant and its thread id from the eligible vector.
  always_comb begin
    gnt = 2'b00;
    id  = T0;
    case (elig)
      2'b01: begin gnt = 2'b01; id = T0; end
      2'b10: begin gnt = 2'b10; id = T1; end
      2'b11: begin
        if (last == T0) begin
          gnt = 2'b10;
          id  = T1;
        end else begin
          gnt = 2'b01;
          id  = T0;
        end
      end
      default: begin gnt = 2'b00; id = T0; end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-thread shared memory port arbiter with round-robin fairness, per-thread
// lock for atomic read-modify-write, and one-cycle load data return.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mem_arbiter_if.slave bus
);

  state_t     state_q, state_d;
  logic       last_q;
  logic       pend_q, pend_id_q;
  word_t      hold0_q, hold1_q;
  logic [1:0] elig;
  logic [1:0] rr_gnt;
  logic       rr_id;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       gnt_any;
  logic       gnt_lock;
  logic       rvalid0, rvalid1;

  // Halted threads and anything during reset are simply not eligible.
  assign elig = {bus.req1 & ~bus.halt1 & reset, bus.req0 & ~bus.halt0 & reset};

  rr_pick2 u_pick (
    .elig (elig),
    .last (last_q),
    .gnt  (rr_gnt),
    .id   (rr_id)
  );

  // State register plus round-robin pointer, pending-load tag and rdata holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      last_q    <= T1;
      pend_q    <= 1'b0;
      pend_id_q <= T0;
      hold0_q   <= '0;
      hold1_q   <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_any) begin
        last_q    <= gnt_id;
        pend_id_q <= gnt_id;
      end
      pend_q <= gnt_any & ~bus.mem_we;
      if (rvalid0) hold0_q <= bus.mem_rdata;
      if (rvalid1) hold1_q <= bus.mem_rdata;
    end
  end

  // Grant decode: round robin in IDLE, owner only while locked.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = T0;
    case (state_q)
      ST_IDLE: begin gnt = rr_gnt;            gnt_id = rr_id; end
      ST_OWN0: begin gnt = {1'b0, elig[0]};   gnt_id = T0;    end
      ST_OWN1: begin gnt = {elig[1], 1'b0};   gnt_id = T1;    end
      default: begin gnt = 2'b00;             gnt_id = T0;    end
    endcase
  end

  assign gnt_any  = |gnt;
  assign gnt_lock = (gnt_id == T1) ? bus.lock1 : bus.lock0;

  // Next state: take ownership on a locked grant, drop it on unlock or halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any && gnt_lock) state_d = (gnt_id == T1) ? ST_OWN1 : ST_OWN0;
      end
      ST_OWN0: begin
        if (bus.halt0 || (gnt[0] && !bus.lock0)) state_d = ST_IDLE;
      end
      ST_OWN1: begin
        if (bus.halt1 || (gnt[1] && !bus.lock1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: grants, memory mux (zero when idle), load return and owner.
  always_comb begin
    bus.gnt0      = gnt[0];
    bus.gnt1      = gnt[1];
    bus.mem_en    = gnt_any;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_any) begin
      bus.mem_we    = (gnt_id == T1) ? bus.we1    : bus.we0;
      bus.mem_addr  = (gnt_id == T1) ? bus.addr1  : bus.addr0;
      bus.mem_wdata = (gnt_id == T1) ? bus.wdata1 : bus.wdata0;
    end
    case (state_q)
      ST_OWN0: bus.owner = {1'b1, T0};
      ST_OWN1: bus.owner = {1'b1, T1};
      default: bus.owner = 2'b00;
    endcase
  end

  assign rvalid0     = pend_q & (pend_id_q == T0);
  assign rvalid1     = pend_q & (pend_id_q == T1);
  assign bus.rvalid0 = rvalid0;
  assign bus.rvalid1 = rvalid1;
  assign bus.rdata0  = rvalid0 ? bus.mem_rdata : hold0_q;
  assign bus.rdata1  = rvalid1 ? bus.mem_rdata : hold1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small registered memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, write on store; unwritten words use preset contents.
  logic [15:0] mem_arr [0:255];
  logic [255:0] written;

  function automatic logic [15:0] preset_word(input logic [7:0] a);
    case (a)
      8'h10:   return 16'h1234;
      8'h40:   return 16'hAAAA;
      8'h50:   return 16'h5555;
      8'h60:   return 16'h6060;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      written <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
        written[bus.mem_addr[7:0]] <= 1'b1;
      end else begin
        bus.mem_rdata <= written[bus.mem_addr[7:0]] ? mem_arr[bus.mem_addr[7:0]]
                                                    : preset_word(bus.mem_addr[7:0]);
      end
    end
  end

  // Comparison helpers.
  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: all thread inputs to quiet values.
  task automatic idle_all();
    bus.req0 = 1'b0;   bus.req1 = 1'b0;
    bus.we0 = 1'b0;    bus.we1 = 1'b0;
    bus.lock0 = 1'b0;  bus.lock1 = 1'b0;
    bus.addr0 = '0;    bus.addr1 = '0;
    bus.wdata0 = '0;   bus.wdata1 = '0;
    bus.halt0 = 1'b0;  bus.halt1 = 1'b0;
  endtask

  logic exp0;

  initial begin
    total = 0;
    bad   = 0;
    idle_all();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    // Reset state.
    chk1("rst_gnt0", bus.gnt0, 1'b0);
    chk1("rst_gnt1", bus.gnt1, 1'b0);
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_rvalid0", bus.rvalid0, 1'b0);
    chk1("rst_rvalid1", bus.rvalid1, 1'b0);
    chk16("rst_rdata0", bus.rdata0, 16'h0000);
    chk16("rst_rdata1", bus.rdata1, 16'h0000);
    chk2("rst_owner", bus.owner, 2'b00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single load by thread 0.
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 16'h0010;
    #1;
    chk1("ld0_gnt0", bus.gnt0, 1'b1);
    chk1("ld0_gnt1", bus.gnt1, 1'b0);
    chk1("ld0_mem_en", bus.mem_en, 1'b1);
    chk1("ld0_mem_we", bus.mem_we, 1'b0);
    chk16("ld0_mem_addr", bus.mem_addr, 16'h0010);
    @(negedge clk);
    bus.req0 = 1'b0;
    #1;
    chk1("ld0_rvalid0", bus.rvalid0, 1'b1);
    chk16("ld0_rdata0", bus.rdata0, 16'h1234);
    chk1("ld0_rvalid1", bus.rvalid1, 1'b0);
    chk1("ld0_idle_en", bus.mem_en, 1'b0);
    chk16("ld0_idle_addr", bus.mem_addr, 16'h0000);
    @(negedge clk);
    #1;
    chk1("ld0_rvalid0_drop", bus.rvalid0, 1'b0);
    chk16("ld0_rdata0_hold", bus.rdata0, 16'h1234);

    // Store by thread 1 (also leaves last=1 so thread 0 wins the next tie).
    @(negedge clk);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0030; bus.wdata1 = 16'hBEEF;
    #1;
    chk1("st1_gnt1", bus.gnt1, 1'b1);
    chk1("st1_gnt0", bus.gnt0, 1'b0);
    chk1("st1_mem_we", bus.mem_we, 1'b1);
    chk16("st1_mem_addr", bus.mem_addr, 16'h0030);
    chk16("st1_mem_wdata", bus.mem_wdata, 16'hBEEF);
    @(negedge clk);
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    #1;
    chk1("st1_no_rvalid1", bus.rvalid1, 1'b0);
    chk16("st1_idle_wdata", bus.mem_wdata, 16'h0000);

    // Continuous contention: 0,1,0,1,0,1.
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 16'h0040;
    bus.req1 = 1'b1; bus.addr1 = 16'h0050;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp0 = ((i % 2) == 0);
      chk1("rr_gnt0", bus.gnt0, exp0);
      chk1("rr_gnt1", bus.gnt1, ~exp0);
      chk1("rr_mem_en", bus.mem_en, 1'b1);
      chk16("rr_mem_addr", bus.mem_addr, exp0 ? 16'h0040 : 16'h0050);
      if (i > 0) begin
        chk1("rr_rvalid0", bus.rvalid0, ~exp0);
        chk1("rr_rvalid1", bus.rvalid1, exp0);
        if (exp0) chk16("rr_rdata1", bus.rdata1, 16'h5555);
        else      chk16("rr_rdata0", bus.rdata0, 16'hAAAA);
      end
      @(negedge clk);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    #1;
    chk1("rr_tail_rvalid1", bus.rvalid1, 1'b1);
    chk16("rr_tail_rdata1", bus.rdata1, 16'h5555);
    chk1("rr_tail_en", bus.mem_en, 1'b0);

    // Thread 0 store of 0x0007 to 0x0020 (leaves last=0).
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0020; bus.wdata0 = 16'h0007;
    #1;
    chk1("st0_gnt0", bus.gnt0, 1'b1);

    // Locked read-modify-write by thread 1 while thread 0 keeps requesting.
    @(negedge clk);
    bus.we0 = 1'b0; bus.addr0 = 16'h0060; bus.wdata0 = 16'h0000;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.lock1 = 1'b1; bus.addr1 = 16'h0020;
    #1;
    chk1("lk_a_gnt1", bus.gnt1, 1'b1);
    chk1("lk_a_gnt0", bus.gnt0, 1'b0);
    chk2("lk_a_owner", bus.owner, 2'b00);
    chk16("lk_a_addr", bus.mem_addr, 16'h0020);
    @(negedge clk);
    bus.we1 = 1'b1; bus.lock1 = 1'b0; bus.wdata1 = 16'h0021;
    #1;
    chk1("lk_b_gnt1", bus.gnt1, 1'b1);
    chk1("lk_b_gnt0", bus.gnt0, 1'b0);
    chk2("lk_b_owner", bus.owner, 2'b11);
    chk1("lk_b_mem_we", bus.mem_we, 1'b1);
    chk16("lk_b_wdata", bus.mem_wdata, 16'h0021);
    chk1("lk_b_rvalid1", bus.rvalid1, 1'b1);
    chk16("lk_b_rdata1", bus.rdata1, 16'h0007);
    @(negedge clk);
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.wdata1 = 16'h0000;
    #1;
    chk1("lk_c_gnt0", bus.gnt0, 1'b1);
    chk1("lk_c_gnt1", bus.gnt1, 1'b0);
    chk2("lk_c_owner", bus.owner, 2'b00);
    chk16("lk_c_addr", bus.mem_addr, 16'h0060);
    @(negedge clk);
    bus.req0 = 1'b0;
    #1;
    chk1("lk_d_rvalid0", bus.rvalid0, 1'b1);
    chk16("lk_d_rdata0", bus.rdata0, 16'h6060);

    // Thread 0 takes a lock, then halts while thread 1 waits.
    @(negedge clk);
    bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 16'h0010;
    #1;
    chk1("hl_a_gnt0", bus.gnt0, 1'b1);
    chk2("hl_a_owner", bus.owner, 2'b00);
    @(negedge clk);
    bus.halt0 = 1'b1;
    bus.req1 = 1'b1; bus.addr1 = 16'h0050;
    #1;
    chk1("hl_b_gnt0", bus.gnt0, 1'b0);
    chk1("hl_b_gnt1", bus.gnt1, 1'b0);
    chk1("hl_b_mem_en", bus.mem_en, 1'b0);
    chk2("hl_b_owner", bus.owner, 2'b10);
    chk1("hl_b_rvalid0", bus.rvalid0, 1'b1);
    chk16("hl_b_rdata0", bus.rdata0, 16'h1234);
    @(negedge clk);
    #1;
    chk1("hl_c_gnt1", bus.gnt1, 1'b1);
    chk1("hl_c_gnt0", bus.gnt0, 1'b0);
    chk2("hl_c_owner", bus.owner, 2'b00);
    chk16("hl_c_addr", bus.mem_addr, 16'h0050);
    @(negedge clk);
    idle_all();
    #1;
    chk1("hl_d_rvalid1", bus.rvalid1, 1'b1);
    chk16("hl_d_rdata1", bus.rdata1, 16'h5555);

    // Thread 1 load, then reset pulse before the next edge.
    @(negedge clk);
    bus.req1 = 1'b1; bus.addr1 = 16'h0050;
    #1;
    chk1("rp_gnt1", bus.gnt1, 1'b1);
    reset = 1'b0;
    #1;
    chk1("rp_in_rst_gnt1", bus.gnt1, 1'b0);
    chk1("rp_in_rst_mem_en", bus.mem_en, 1'b0);
    #1;
    reset = 1'b1;
    bus.req1 = 1'b0;
    @(negedge clk);
    #1;
    chk1("rp_rvalid1", bus.rvalid1, 1'b0);
    chk16("rp_rdata1", bus.rdata1, 16'h0000);
    chk2("rp_owner", bus.owner, 2'b00);
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 16'h0010;
    bus.req1 = 1'b1; bus.addr1 = 16'h0050;
    #1;
    chk1("rp_tie_gnt0", bus.gnt0, 1'b1);
    chk1("rp_tie_gnt1", bus.gnt1, 1'b0);

    // Halted thread 1 requesting for 4 cycles.
    @(negedge clk);
    bus.req0 = 1'b0;
    bus.halt1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("hx_gnt1", bus.gnt1, 1'b0);
      chk1("hx_mem_en", bus.mem_en, 1'b0);
      @(negedge clk);
    end
    idle_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
